// File: rtl/riscv_ctrl_pkg.sv
// +-------------------------------------------------------------------------+
// | riscv_ctrl_pkg : shared state, opcode and mux-select encodings           |
// | Revision: 1.0                                                            |
// +-------------------------------------------------------------------------+
`default_nettype none

package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        ALUWB    = 4'd7,
        EXECUTEI = 4'd8,
        BEQ      = 4'd9,
        JAL      = 4'd10
    } statetype_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

endpackage

`default_nettype wire

// File: rtl/instr_dec.sv
// +-------------------------------------------------------------------------+
// | instr_dec : opcode -> immediate format select for the extender           |
// | Revision: 1.0                                                            |
// +-------------------------------------------------------------------------+
`default_nettype none

module instr_dec
    import riscv_ctrl_pkg::*;
(
    input  logic [6:0] op,
    output logic [1:0] imm_src
);

    always_comb begin
        imm_src = 2'bxx;
        case (op)
            OP_LOAD,
            OP_I:     imm_src = IMM_I;
            OP_STORE: imm_src = IMM_S;
            OP_BEQ:   imm_src = IMM_B;
            OP_JAL:   imm_src = IMM_J;
            default:  imm_src = 2'bxx;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/main_fsm.sv
// +-------------------------------------------------------------------------+
// | main_fsm : multicycle RV32I control FSM (fetch/decode/execute/mem/wb)    |
// | Revision: 1.0                                                            |
// +-------------------------------------------------------------------------+
`default_nettype none

module main_fsm
    import riscv_ctrl_pkg::*;
#(
    parameter bit USE_MEM_READY = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic       mem_ready,
    output logic       pc_update,
    output logic       branch,
    output logic       ir_write,
    output logic       reg_write,
    output logic       mem_write,
    output logic       adr_src,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] imm_src,
    output logic       illegal_op,
    output logic [3:0] state_dbg
);

    statetype_t state_q;
    statetype_t state_d;
    logic       w_ready;

    assign w_ready   = USE_MEM_READY ? mem_ready : 1'b1;
    assign state_dbg = state_q;

    instr_dec u_instr_dec (
        .op      (op),
        .imm_src (imm_src)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_update  = 1'b0;
        branch     = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        mem_write  = 1'b0;
        adr_src    = 1'b0;
        result_src = RES_ALUOUT;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_RS2;
        alu_op     = ALUOP_ADD;
        illegal_op = 1'b0;

        case (state_q)
            FETCH: begin
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALURESULT;
                ir_write   = w_ready;
                pc_update  = w_ready;
                if (w_ready) state_d = DECODE;
            end
            DECODE: begin
                // Precompute the branch target into ALUOut while decoding.
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                case (op)
                    OP_LOAD,
                    OP_STORE: state_d = MEMADR;
                    OP_R:     state_d = EXECUTER;
                    OP_I:     state_d = EXECUTEI;
                    OP_BEQ:   state_d = BEQ;
                    OP_JAL:   state_d = JAL;
                    default: begin
                        state_d    = FETCH;
                        illegal_op = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                state_d   = op[5] ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                adr_src = 1'b1;
                if (w_ready) state_d = MEMWB;
            end
            MEMWB: begin
                result_src = RES_DATA;
                reg_write  = 1'b1;
                state_d    = FETCH;
            end
            MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = w_ready;
                if (w_ready) state_d = FETCH;
            end
            EXECUTER: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_RS2;
                alu_op    = ALUOP_FUNCT;
                state_d   = ALUWB;
            end
            EXECUTEI: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALUOP_FUNCT;
                state_d   = ALUWB;
            end
            ALUWB: begin
                reg_write = 1'b1;
                state_d   = FETCH;
            end
            BEQ: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_RS2;
                alu_op    = ALUOP_SUB;
                branch    = 1'b1;
                state_d   = FETCH;
            end
            JAL: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_FOUR;
                pc_update = 1'b1;
                state_d   = ALUWB;
            end
            default: state_d = FETCH;
        endcase

        // Reset masks everything combinationally so no enable glitches high.
        if (reset) begin
            pc_update  = 1'b0;
            branch     = 1'b0;
            ir_write   = 1'b0;
            reg_write  = 1'b0;
            mem_write  = 1'b0;
            adr_src    = 1'b0;
            result_src = 2'b00;
            alu_src_a  = 2'b00;
            alu_src_b  = 2'b00;
            alu_op     = 2'b00;
            illegal_op = 1'b0;
            state_d    = FETCH;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_main_fsm.sv
// +-------------------------------------------------------------------------+
// | tb_main_fsm : directed self-checking bench for main_fsm                  |
// | Revision: 1.0                                                            |
// +-------------------------------------------------------------------------+
`default_nettype none

module tb_main_fsm;

    logic       clk;
    logic       reset;
    logic [6:0] op;
    logic       mem_ready;
    logic       pc_update, branch, ir_write, reg_write, mem_write, adr_src;
    logic [1:0] result_src, alu_src_a, alu_src_b, alu_op, imm_src;
    logic       illegal_op;
    logic [3:0] state_dbg;

    int checks   = 0;
    int failures = 0;

    main_fsm #(.USE_MEM_READY(1'b1)) dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .mem_ready  (mem_ready),
        .pc_update  (pc_update),
        .branch     (branch),
        .ir_write   (ir_write),
        .reg_write  (reg_write),
        .mem_write  (mem_write),
        .adr_src    (adr_src),
        .result_src (result_src),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .imm_src    (imm_src),
        .illegal_op (illegal_op),
        .state_dbg  (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_enables_low(input string tag);
        check({tag, "_en"}, {pc_update, branch, ir_write, reg_write, mem_write, illegal_op}, 8'h00);
    endtask

    initial begin
        reset     = 1'b1;
        op        = 7'b0000000;
        mem_ready = 1'b1;

        // Reset held: FETCH, all enables and selects zero
        tick();
        tick();
        check("rst_state", state_dbg, 8'd0);
        check_enables_low("rst");
        check("rst_srcb", alu_src_b, 8'd0);
        check("rst_res", result_src, 8'd0);
        reset = 1'b0;
        #1;
        check("fetch_irw", ir_write, 8'd1);
        check("fetch_pcu", pc_update, 8'd1);
        check("fetch_srcb", alu_src_b, 8'd2);
        check("fetch_res", result_src, 8'd2);

        // FETCH stall
        mem_ready = 1'b0;
        #1;
        check("fstall_irw", {ir_write, pc_update}, 8'd0);
        tick();
        check("fstall_state", state_dbg, 8'd0);
        mem_ready = 1'b1;

        // lw: 0,1,2,3,4,0
        op = 7'b0000011;
        #1;
        check("lw_imm0", imm_src, 8'd0);
        tick();
        check("lw_s1", state_dbg, 8'd1);
        check("lw_dec_srca", alu_src_a, 8'd1);
        check("lw_dec_srcb", alu_src_b, 8'd1);
        check("lw_dec_rw", reg_write, 8'd0);
        tick();
        check("lw_s2", state_dbg, 8'd2);
        check("lw_madr_srca", alu_src_a, 8'd2);
        check("lw_madr_rw", reg_write, 8'd0);
        tick();
        check("lw_s3", state_dbg, 8'd3);
        check("lw_mrd_adr", adr_src, 8'd1);
        check("lw_mrd_rw", reg_write, 8'd0);
        tick();
        check("lw_s4", state_dbg, 8'd4);
        check("lw_wb_rw", reg_write, 8'd1);
        check("lw_wb_res", result_src, 8'd1);
        check("lw_imm", imm_src, 8'd0);
        tick();
        check("lw_s0", state_dbg, 8'd0);
        check("lw_s0_rw", reg_write, 8'd0);

        // sw with 3-cycle stall in MEMWRITE
        op = 7'b0100011;
        tick();
        check("sw_s1", state_dbg, 8'd1);
        check("sw_imm", imm_src, 8'd1);
        tick();
        check("sw_s2", state_dbg, 8'd2);
        tick();
        mem_ready = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            check("sw_stall_state", state_dbg, 8'd5);
            check("sw_stall_mw", mem_write, 8'd0);
            if (i < 2) tick();
        end
        mem_ready = 1'b1;
        #1;
        check("sw_mw", mem_write, 8'd1);
        check("sw_adr", adr_src, 8'd1);
        tick();
        check("sw_s0", state_dbg, 8'd0);
        check("sw_mw_off", mem_write, 8'd0);

        // R-type: 0,1,6,7,0
        op = 7'b0110011;
        tick();
        check("r_s1", state_dbg, 8'd1);
        tick();
        check("r_s6", state_dbg, 8'd6);
        check("r_aluop", alu_op, 8'd2);
        check("r_srcb", alu_src_b, 8'd0);
        check("r_srca", alu_src_a, 8'd2);
        tick();
        check("r_s7", state_dbg, 8'd7);
        check("r_rw", reg_write, 8'd1);
        check("r_res", result_src, 8'd0);
        tick();
        check("r_s0", state_dbg, 8'd0);

        // I-type: 0,1,8,7,0
        op = 7'b0010011;
        tick();
        check("i_s1", state_dbg, 8'd1);
        tick();
        check("i_s8", state_dbg, 8'd8);
        check("i_srcb", alu_src_b, 8'd1);
        check("i_aluop", alu_op, 8'd2);
        check("i_imm", imm_src, 8'd0);
        tick();
        check("i_s7", state_dbg, 8'd7);
        tick();
        check("i_s0", state_dbg, 8'd0);

        // beq: 0,1,9,0
        op = 7'b1100011;
        tick();
        check("beq_s1", state_dbg, 8'd1);
        tick();
        check("beq_s9", state_dbg, 8'd9);
        check("beq_br", branch, 8'd1);
        check("beq_aluop", alu_op, 8'd1);
        check("beq_imm", imm_src, 8'd2);
        check("beq_pcu", pc_update, 8'd0);
        tick();
        check("beq_s0", state_dbg, 8'd0);
        check("beq_br_off", branch, 8'd0);

        // jal: 0,1,10,7,0
        op = 7'b1101111;
        tick();
        check("jal_s1", state_dbg, 8'd1);
        tick();
        check("jal_s10", state_dbg, 8'd10);
        check("jal_pcu", pc_update, 8'd1);
        check("jal_imm", imm_src, 8'd3);
        check("jal_srca", alu_src_a, 8'd1);
        check("jal_srcb", alu_src_b, 8'd2);
        tick();
        check("jal_s7", state_dbg, 8'd7);
        check("jal_wb_pcu", pc_update, 8'd0);
        tick();
        check("jal_s0", state_dbg, 8'd0);

        // Illegal opcode: DECODE then FETCH, one-cycle pulse
        op = 7'b1110011;
        tick();
        check("ill_s1", state_dbg, 8'd1);
        check("ill_pulse", illegal_op, 8'd1);
        check("ill_wr", {reg_write, mem_write}, 8'd0);
        tick();
        check("ill_s0", state_dbg, 8'd0);
        check("ill_off", illegal_op, 8'd0);
        check("ill_wr2", {reg_write, mem_write}, 8'd0);

        // Reset asserted mid-MEMREAD
        op = 7'b0000011;
        tick();
        tick();
        tick();
        check("mrst_pre", state_dbg, 8'd3);
        #2;
        reset = 1'b1;
        #1;
        check("mrst_state", state_dbg, 8'd0);
        check_enables_low("mrst");
        check("mrst_srcb", alu_src_b, 8'd0);
        tick();
        check("mrst_hold", state_dbg, 8'd0);
        check_enables_low("mrst_hold");
        reset = 1'b0;
        #1;
        check("mrst_irw", ir_write, 8'd1);
        check("mrst_pcu", pc_update, 8'd1);
        check("mrst_srcb2", alu_src_b, 8'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/main_fsm.md
Name: main_fsm

Overview:
- Multicycle control state machine for the RV32I multicycle core, directly upstream of the ALU decoder.
- Sequences each instruction through fetch/decode/execute/memory/writeback.
- Drives datapath enables and mux selects, the 2-bit alu_op consumed by the ALU decoder, and imm_src for the immediate extender.
- Supported instructions: lw, sw, R-type, I-type ALU, beq, jal.

Parameters:
- USE_MEM_READY, 1: when 1, memory-access states stall until mem_ready=1; when 0, mem_ready is ignored and treated as 1.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- op  in  7  instr[6:0] from the instruction register
- mem_ready  in  1  memory completed the current access this cycle
- pc_update  out  1  PC write enable (unconditional)
- branch  out  1  qualify PC write with ALU zero
- ir_write  out  1  instruction register / OldPC load
- reg_write  out  1  register file write enable
- mem_write  out  1  data memory write enable
- adr_src  out  1  memory address: 0=PC, 1=Result
- result_src  out  2  00=ALUOut, 01=Data, 10=ALUResult
- alu_src_a  out  2  00=PC, 01=OldPC, 10=rs1 data
- alu_src_b  out  2  00=rs2 data, 01=ImmExt, 10=constant 4
- alu_op  out  2  00=add, 01=subtract (beq), 10=funct-decoded
- imm_src  out  2  00=I, 01=S, 10=B, 11=J
- illegal_op  out  1  one-cycle pulse: unsupported opcode seen in DECODE
- state_dbg  out  4  current state encoding, for debug/verification

Behaviour:
- Clock, reset and output style:
  - Clock is clk; reset is asynchronous, active-high.
  - Reset forces state=FETCH.
  - Moore outputs, decoded combinationally from the state register.
  - Exception: the FETCH and memory-state enables also depend on mem_ready.
  - While reset=1: all enables 0 (pc_update, branch, ir_write, reg_write, mem_write, illegal_op) and all selects 00.
  - imm_src is a pure function of op in every state, including during reset.
- Any output not listed for a state is 0/00.
- Per-state outputs and next state:
  - FETCH: adr_src=0, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10; ir_write=pc_update=mem_ready.
    - mem_ready=1 -> DECODE; otherwise hold in FETCH with both enables 0.
  - DECODE: alu_src_a=01, alu_src_b=01, alu_op=00 (branch target precompute).
    - lw 0000011 or sw 0100011 -> MEMADR
    - 0110011 -> EXECUTER
    - 0010011 -> EXECUTEI
    - 1100011 -> BEQ
    - 1101111 -> JAL
    - any other opcode -> FETCH with illegal_op=1 for this cycle only
  - MEMADR: alu_src_a=10, alu_src_b=01, alu_op=00.
    - op[5]=0 -> MEMREAD; op[5]=1 -> MEMWRITE
  - MEMREAD: adr_src=1, result_src=00.
    - mem_ready=1 -> MEMWB; otherwise hold
  - MEMWB: result_src=01, reg_write=1 -> FETCH
  - MEMWRITE: adr_src=1, result_src=00, mem_write=mem_ready.
    - mem_ready=1 -> FETCH; otherwise hold
    - mem_write stays 0 while stalled.
  - EXECUTER: alu_src_a=10, alu_src_b=00, alu_op=10 -> ALUWB
  - EXECUTEI: alu_src_a=10, alu_src_b=01, alu_op=10 -> ALUWB
  - ALUWB: result_src=00, reg_write=1 -> FETCH
  - BEQ: alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00, branch=1 -> FETCH
  - JAL: alu_src_a=01, alu_src_b=10, alu_op=00, result_src=00, pc_update=1 -> ALUWB
- Latency with mem_ready held 1:
  - lw 5 cycles
  - sw, R-type, I-type 4 cycles
  - jal 4 cycles
  - beq 3 cycles
  - illegal opcode 2 cycles
- Single-cycle enables: pc_update, ir_write, reg_write and mem_write each stay high for at most one cycle per state visit.
- State encodings are fixed for state_dbg:
  - FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5
  - EXECUTER=6, ALUWB=7, EXECUTEI=8, BEQ=9, JAL=10
  - codes 11-15 are unreachable and recover to FETCH on the next clock.
- Reset asserted mid-instruction: state goes to FETCH immediately (asynchronous); no write enable may glitch high.
- USE_MEM_READY=0: the FSM behaves identically with mem_ready tied to 1.

Decomposition:
- Shared package riscv_ctrl_pkg:
  - state enum statetype_t with the encodings above
  - opcode localparams OP_LOAD, OP_STORE, OP_R, OP_I, OP_BEQ, OP_JAL
  - alu_op localparams ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT
  - result_src, alu_src_a, alu_src_b select localparams
- One sub-module, instr_dec: combinational op -> imm_src.
  - I for load/I-type, S for store, B for beq, J for jal; 2'bxx otherwise.

Test Plan:
- Reset: assert reset mid-MEMREAD -> state_dbg=0 immediately, all enables 0 while reset high; after release, first FETCH with mem_ready=1 gives ir_write=1, pc_update=1, alu_src_b=10.
- lw: op=0000011, mem_ready=1 -> state sequence 0,1,2,3,4,0; reg_write=1 only in state 4 with result_src=01; imm_src=00 throughout.
- sw with stall: op=0100011, mem_ready=0 for 3 cycles in MEMWRITE -> hold in state 5 with mem_write=0, then mem_write=1 for exactly one cycle, then state 0.
- R-type and I-type: op=0110011 -> 0,1,6,7,0 with alu_op=10, alu_src_b=00 in state 6; op=0010011 -> 0,1,8,7,0 with alu_src_b=01.
- beq and jal: op=1100011 -> state 9 with branch=1, alu_op=01, imm_src=10; op=1101111 -> 0,1,10,7,0 with pc_update=1 in state 10, imm_src=11.
- Illegal opcode: op=1110011 -> DECODE then FETCH; illegal_op high for exactly 1 cycle; no reg_write or mem_write pulse.
